// File: rtl/ucdp_fifo_pkg.sv
// Shared types for the ucdp_fifo read-side adapters.
package ucdp_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ucdp_fifo_rds_state_t;

endpackage

// File: rtl/ucdp_fifo_rdstream.sv
// Drains a ucdp_fifo read port into a registered valid/ready stream through a
// 2-entry buffer (head drives the output, skid catches the word in flight).
module ucdp_fifo_rdstream #(
    parameter int width_p = 8
) (
    input  logic               main_clk_i,
    input  logic               main_rst_an_i,
    input  logic               fifo_empty_i,
    input  logic [width_p-1:0] fifo_data_i,
    output logic               fifo_rd_ena_o,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [width_p-1:0] out_data_o,
    output logic [1:0]         level_o
);

    import ucdp_fifo_pkg::*;

    ucdp_fifo_rds_state_t state_q;
    ucdp_fifo_rds_state_t state_d;
    logic [width_p-1:0]   head_q;
    logic [width_p-1:0]   skid_q;
    logic                 fetch;
    logic                 pop;

    // Fetch never looks at out_ready_i, which keeps the FIFO side free of
    // any combinational path from the consumer.
    always_comb begin
        fetch   = ~fifo_empty_i & (state_q != TWO) & ~flush_i;
        pop     = (state_q != EMPTY) & out_ready_i;
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (fetch) state_d = ONE;
            ONE: begin
                if (fetch && !pop) begin
                    state_d = TWO;
                end else if (!fetch && pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush only drops valid; the data registers are left untouched.
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: if (fetch) head_q <= fifo_data_i;
                ONE: begin
                    if (fetch && pop) begin
                        head_q <= fifo_data_i;
                    end else if (fetch) begin
                        skid_q <= fifo_data_i;
                    end
                end
                TWO: if (pop && !flush_i) head_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign fifo_rd_ena_o = fetch;
    assign out_valid_o   = (state_q != EMPTY);
    assign out_data_o    = head_q;
    assign level_o       = state_q;

endmodule

// File: tb/tb_ucdp_fifo_rdstream.sv
// Directed and randomised checks of ucdp_fifo_rdstream against a simple FIFO
// model and an in-order scoreboard.
module tb_ucdp_fifo_rdstream;

    logic       mainClk;
    logic       mainRstAn;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoRdEna;
    logic       flush;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic [1:0] level;

    logic [7:0] fifoMem [256];
    logic [7:0] wrPtr;
    logic [7:0] rdPtr;
    logic [7:0] fill;
    int         rdPulses;
    int         testCount;
    int         failCount;

    ucdp_fifo_rdstream #(.width_p(8)) dut (
        .main_clk_i    (mainClk),
        .main_rst_an_i (mainRstAn),
        .fifo_empty_i  (fifoEmpty),
        .fifo_data_i   (fifoData),
        .fifo_rd_ena_o (fifoRdEna),
        .flush_i       (flush),
        .out_valid_o   (outValid),
        .out_ready_i   (outReady),
        .out_data_o    (outData),
        .level_o       (level)
    );

    initial mainClk = 1'b0;
    always #5 mainClk = ~mainClk;

    // FIFO model: combinational head, pop on the clock edge when rd_ena is high.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoData  = fifoMem[rdPtr];
    assign fill      = wrPtr - rdPtr;

    always @(posedge mainClk or negedge mainRstAn) begin
        if (!mainRstAn) begin
            rdPtr    <= 8'd0;
            rdPulses <= 0;
        end else if (fifoRdEna) begin
            rdPtr    <= rdPtr + 8'd1;
            rdPulses <= rdPulses + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic flushIn);
        outReady = ready;
        flush    = flushIn;
        #1;
    endtask

    task automatic pushWord(input logic [7:0] value);
        fifoMem[wrPtr] = value;
        wrPtr          = wrPtr + 8'd1;
    endtask

    task automatic nextCycle();
        @(negedge mainClk);
    endtask

    logic [7:0] table4Data  [8];
    logic [1:0] table4Level [8];
    logic       table4Ready [8];
    logic       table4RdEna [8];

    initial begin
        testCount = 0;
        failCount = 0;
        wrPtr     = 8'd0;
        outReady  = 1'b0;
        flush     = 1'b0;
        mainRstAn = 1'b0;
        for (int i = 0; i < 256; i++) fifoMem[i] = 8'd0;
        repeat (3) nextCycle();
        mainRstAn = 1'b1;

        // Reset state.
        nextCycle();
        #1;
        checkOutput("rstValid", 32'(outValid), 32'd0);
        checkOutput("rstLevel", 32'(level), 32'd0);
        checkOutput("rstRdEna", 32'(fifoRdEna), 32'd0);
        checkOutput("rstData", 32'(outData), 32'd0);

        // Streaming at full rate with ready held high.
        pushWord(8'h11); pushWord(8'h22); pushWord(8'h33);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2RdEna0", 32'(fifoRdEna), 32'd1);
        checkOutput("t2Valid0", 32'(outValid), 32'd0);
        nextCycle();
        checkOutput("t2Data1", 32'(outData), 32'h11);
        checkOutput("t2Valid1", 32'(outValid), 32'd1);
        nextCycle();
        checkOutput("t2Data2", 32'(outData), 32'h22);
        nextCycle();
        checkOutput("t2Data3", 32'(outData), 32'h33);
        checkOutput("t2RdEna3", 32'(fifoRdEna), 32'd0);
        nextCycle();
        checkOutput("t2Valid4", 32'(outValid), 32'd0);
        checkOutput("t2Level4", 32'(level), 32'd0);

        // Back-pressure fills the buffer; only two words leave the FIFO.
        begin
            int basePulses;
            basePulses = rdPulses;
            applyStimulus(1'b0, 1'b0);
            pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
            repeat (3) nextCycle();
            checkOutput("t3Level", 32'(level), 32'd2);
            checkOutput("t3Fill", 32'(fill), 32'd2);
            checkOutput("t3Pulses", 32'(rdPulses - basePulses), 32'd2);
            checkOutput("t3Data", 32'(outData), 32'h11);
            applyStimulus(1'b1, 1'b0);
            checkOutput("t3Out0", 32'(outData), 32'h11);
            nextCycle();
            checkOutput("t3Out1", 32'(outData), 32'h22);
            nextCycle();
            checkOutput("t3Out2", 32'(outData), 32'h33);
            nextCycle();
            checkOutput("t3Out3", 32'(outData), 32'h44);
            nextCycle();
            checkOutput("t3Drained", 32'(outValid), 32'd0);
        end

        // Ready toggling from a full buffer.
        table4Ready = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        table4Level = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
        table4Data  = '{8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3, 8'hA4, 8'hA4, 8'hA4};
        table4RdEna = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(1'b0, 1'b0);
        pushWord(8'hA1); pushWord(8'hA2); pushWord(8'hA3); pushWord(8'hA4);
        repeat (3) nextCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table4Ready[i], 1'b0);
            checkOutput($sformatf("t4Level%0d", i), 32'(level), 32'(table4Level[i]));
            checkOutput($sformatf("t4Data%0d", i), 32'(outData), 32'(table4Data[i]));
            checkOutput($sformatf("t4RdEna%0d", i), 32'(fifoRdEna), 32'(table4RdEna[i]));
            nextCycle();
        end

        // Flush with a full buffer and a non-empty FIFO.
        applyStimulus(1'b0, 1'b0);
        pushWord(8'hB1); pushWord(8'hB2); pushWord(8'hB3); pushWord(8'hB4);
        repeat (3) nextCycle();
        checkOutput("t5PreLevel", 32'(level), 32'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5RdEnaFlush", 32'(fifoRdEna), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5Level", 32'(level), 32'd0);
        checkOutput("t5Valid", 32'(outValid), 32'd0);
        checkOutput("t5Fill", 32'(fill), 32'd2);
        checkOutput("t5DataKept", 32'(outData), 32'hB1);
        checkOutput("t5Refetch", 32'(fifoRdEna), 32'd1);
        nextCycle();
        checkOutput("t5Head", 32'(outData), 32'hB3);
        nextCycle();
        checkOutput("t5Full", 32'(level), 32'd2);
        checkOutput("t5FifoEmpty", 32'(fill), 32'd0);
        applyStimulus(1'b1, 1'b0);
        nextCycle();
        checkOutput("t5Tail", 32'(outData), 32'hB4);
        nextCycle();
        checkOutput("t5End", 32'(level), 32'd0);

        // Random ready and FIFO refill against an in-order scoreboard.
        begin
            logic [7:0] nextPush;
            logic [7:0] nextExp;
            int         budget;
            nextPush = 8'h00;
            nextExp  = 8'h00;
            for (int c = 0; c < 10000; c++) begin
                if (($urandom_range(0, 1) == 1) && (fill < 8'd250)) begin
                    pushWord(nextPush);
                    nextPush = nextPush + 8'd1;
                end
                applyStimulus(1'($urandom_range(0, 1)), 1'b0);
                checkOutput("t6RdEnaLegal", 32'(fifoRdEna & (fifoEmpty | (level == 2'd2))), 32'd0);
                if (outValid && outReady) begin
                    checkOutput("t6Order", 32'(outData), 32'(nextExp));
                    nextExp = nextExp + 8'd1;
                end
                nextCycle();
            end
            applyStimulus(1'b1, 1'b0);
            budget = 600;
            while ((outValid || !fifoEmpty) && budget > 0) begin
                if (outValid) begin
                    checkOutput("t6Order", 32'(outData), 32'(nextExp));
                    nextExp = nextExp + 8'd1;
                end
                nextCycle();
                #1;
                budget--;
            end
            checkOutput("t6DrainTimeout", 32'(budget > 0), 32'd1);
            checkOutput("t6AllDelivered", 32'(nextExp), 32'(nextPush));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
